// File: rtl/alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pkg: opcodes, flag bit indices and datapath defaults shared by ALU and writeback.
// Revision: 1.0
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_OPCODE      = 4;
  localparam int DEF_REGS_CODING = 3;
  localparam int DEF_FLAGS       = 4;

  localparam int CARRY    = 0;
  localparam int SIGN     = 1;
  localparam int OVERFLOW = 2;
  localparam int ZERO     = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_SHL  = 4'b0110,
    OP_SHR  = 4'b0111,
    OP_ROL  = 4'b1000,
    OP_ROR  = 4'b1001,
    OP_ADC  = 4'b1010,
    OP_SBB  = 4'b1011,
    OP_CMP  = 4'b1100,
    OP_INC  = 4'b1101,
    OP_DEC  = 4'b1110
  } alu_op_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_scoreboard: one busy bit per register, set/clear ports (set wins), two lookups.
// Revision: 1.0
// ----------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int REGS_CODING = 3,
  parameter int NREGS       = 2 ** REGS_CODING
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [REGS_CODING-1:0] set_addr,
  input  logic                   clr_en,
  input  logic [REGS_CODING-1:0] clr_addr,
  input  logic [REGS_CODING-1:0] lk_addr_a,
  input  logic [REGS_CODING-1:0] lk_addr_b,
  output logic                   busy_a,
  output logic                   busy_b
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    // Applied after the clear so a new producer keeps the register busy.
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_a = busy_q[lk_addr_a];
  assign busy_b = busy_q[lk_addr_b];

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_writeback: commits ALU results to the regfile, holds flags, bypassed operand reads.
// Revision: 1.0
// ----------------------------------------------------------------------------
module alu_writeback
  import alu_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int OPCODE      = DEF_OPCODE,
  parameter int REGS_CODING = DEF_REGS_CODING,
  parameter int FLAGS       = DEF_FLAGS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_en,
  input  logic [OPCODE-1:0]      issue_opcode,
  input  logic [REGS_CODING-1:0] issue_dest,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [REGS_CODING-1:0] alu_dest,
  input  logic [FLAGS-1:0]       alu_flags,
  input  logic [REGS_CODING-1:0] rd_addr_a,
  input  logic [REGS_CODING-1:0] rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_a,
  output logic [WIDTH-1:0]       rd_data_b,
  output logic                   rd_busy_a,
  output logic                   rd_busy_b,
  output logic [FLAGS-1:0]       flags,
  output logic                   cin,
  output logic                   wb_valid,
  output logic [REGS_CODING-1:0] wb_dest,
  output logic [WIDTH-1:0]       wb_data
);

  localparam int NREGS = 2 ** REGS_CODING;

  logic              pending_q, pending_d;
  logic [OPCODE-1:0] pend_op_q, pend_op_d;
  logic [FLAGS-1:0]  flags_q,   flags_d;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];

  logic commit_wr;
  logic hit_a, hit_b;
  logic sb_busy_a, sb_busy_b;

  // A compare only updates flags, so it neither writes nor bypasses.
  assign commit_wr = pending_q && (pend_op_q != OPCODE'(OP_CMP));

  always_comb begin
    pending_d = issue_en;
    pend_op_d = issue_en ? issue_opcode : pend_op_q;
    flags_d   = pending_q ? alu_flags : flags_q;
    regs_d    = regs_q;
    if (commit_wr) regs_d[alu_dest] = alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      pend_op_q <= '0;
      flags_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      pend_op_q <= pend_op_d;
      flags_q   <= flags_d;
      regs_q    <= regs_d;
    end
  end

  reg_scoreboard #(
    .REGS_CODING (REGS_CODING),
    .NREGS       (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue_en),
    .set_addr  (issue_dest),
    .clr_en    (pending_q),
    .clr_addr  (alu_dest),
    .lk_addr_a (rd_addr_a),
    .lk_addr_b (rd_addr_b),
    .busy_a    (sb_busy_a),
    .busy_b    (sb_busy_b)
  );

  assign hit_a = commit_wr && (alu_dest == rd_addr_a);
  assign hit_b = commit_wr && (alu_dest == rd_addr_b);

  assign rd_data_a = hit_a ? alu_result : regs_q[rd_addr_a];
  assign rd_data_b = hit_b ? alu_result : regs_q[rd_addr_b];
  assign rd_busy_a = sb_busy_a && !hit_a;
  assign rd_busy_b = sb_busy_b && !hit_b;

  assign flags    = flags_q;
  assign cin      = flags_q[CARRY];
  assign wb_valid = pending_q;
  assign wb_dest  = alu_dest;
  assign wb_data  = alu_result;

endmodule : alu_writeback
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_writeback: directed scenarios plus random traffic against a reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_alu_writeback;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic [3:0]  issue_opcode;
  logic [2:0]  issue_dest;
  logic [31:0] alu_result;
  logic [2:0]  alu_dest;
  logic [3:0]  alu_flags;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic [3:0]  flags;
  logic        cin;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .issue_en     (issue_en),
    .issue_opcode (issue_opcode),
    .issue_dest   (issue_dest),
    .alu_result   (alu_result),
    .alu_dest     (alu_dest),
    .alu_flags    (alu_flags),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .rd_busy_a    (rd_busy_a),
    .rd_busy_b    (rd_busy_b),
    .flags        (flags),
    .cin          (cin),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: register values, flags, and per-register count of outstanding producers.
  logic [31:0] m_regs [8];
  logic [3:0]  m_flags;
  int          m_cnt  [8];
  // The op the model ALU is currently holding in its output registers.
  bit          if_v;
  logic [3:0]  if_op;
  logic [2:0]  if_dest;
  logic [31:0] if_res;
  logic [3:0]  if_flg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit fwd(input logic [2:0] a);
    return if_v && (if_op != OP_CMP) && (if_dest == a);
  endfunction

  function automatic logic [31:0] exp_data(input logic [2:0] a);
    return fwd(a) ? if_res : m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    return (m_cnt[a] > 0) && !fwd(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_flags = '0;
    if_v    = 1'b0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input bit r, input bit en, input logic [3:0] op, input logic [2:0] d,
                      input logic [31:0] res, input logic [3:0] flg,
                      input logic [2:0] ra, input logic [2:0] rb);
    rst          = r;
    issue_en     = en;
    issue_opcode = op;
    issue_dest   = d;
    rd_addr_a    = ra;
    rd_addr_b    = rb;
    alu_result   = if_v ? if_res  : 32'($urandom);
    alu_dest     = if_v ? if_dest : 3'($urandom);
    alu_flags    = if_v ? if_flg  : 4'($urandom);
    @(negedge clk);
    check("wb_valid", {31'd0, wb_valid}, {31'd0, if_v});
    if (if_v) begin
      check("wb_dest", {29'd0, wb_dest}, {29'd0, if_dest});
      check("wb_data", wb_data, if_res);
    end
    check("flags", {28'd0, flags}, {28'd0, m_flags});
    check("cin", {31'd0, cin}, {31'd0, m_flags[CARRY]});
    check("rd_data_a", rd_data_a, exp_data(ra));
    check("rd_data_b", rd_data_b, exp_data(rb));
    check("rd_busy_a", {31'd0, rd_busy_a}, {31'd0, exp_busy(ra)});
    check("rd_busy_b", {31'd0, rd_busy_b}, {31'd0, exp_busy(rb)});
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (if_v) begin
        m_flags = if_flg;
        if (if_op != OP_CMP) m_regs[if_dest] = if_res;
        m_cnt[if_dest]--;
      end
      if (en) begin
        m_cnt[d]++;
        if_v    = 1'b1;
        if_op   = op;
        if_dest = d;
        if_res  = res;
        if_flg  = flg;
      end else begin
        if_v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    step(1'b0, 1'b0, OP_ADD, 3'd0, 32'd0, 4'd0, ra, rb);
  endtask

  task automatic peek_a(input logic [2:0] a);
    rd_addr_a = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; issue_en = 1'b0; issue_opcode = '0; issue_dest = '0;
    alu_result = '0; alu_dest = '0; alu_flags = '0; rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    idle(3'd0, 3'd7);
    check("reset_flags", {28'd0, flags}, 32'd0);
    check("reset_wb_valid", {31'd0, wb_valid}, 32'd0);

    // ADD to r3 returning 12
    step(1'b0, 1'b1, OP_ADD, 3'd3, 32'd12, 4'b0000, 3'd3, 3'd0);
    idle(3'd3, 3'd3);
    idle(3'd3, 3'd0);
    peek_a(3'd3);
    check("t1_r3", rd_data_a, 32'd12);
    check("t1_busy", {31'd0, rd_busy_a}, 32'd0);

    // CMP on r2 holding 55 updates flags only
    step(1'b0, 1'b1, OP_ADD, 3'd2, 32'd55, 4'b0000, 3'd2, 3'd0);
    step(1'b0, 1'b1, OP_CMP, 3'd2, 32'd0, 4'b1000, 3'd2, 3'd2);
    idle(3'd2, 3'd2);
    idle(3'd2, 3'd1);
    peek_a(3'd2);
    check("t2_r2", rd_data_a, 32'd55);
    check("t2_flags", {28'd0, flags}, 32'h8);

    // Bypass of 0xDEADBEEF into r5 in the commit cycle
    step(1'b0, 1'b1, OP_XOR, 3'd5, 32'hDEADBEEF, 4'b0010, 3'd5, 3'd5);
    idle(3'd5, 3'd1);
    idle(3'd5, 3'd5);

    // Back-to-back producers of r4
    step(1'b0, 1'b1, OP_ADD, 3'd4, 32'h1111, 4'b0000, 3'd4, 3'd4);
    step(1'b0, 1'b1, OP_SUB, 3'd4, 32'h2222, 4'b0000, 3'd2, 3'd4);
    idle(3'd2, 3'd4);
    idle(3'd4, 3'd4);
    peek_a(3'd4);
    check("t4_r4", rd_data_a, 32'h2222);
    check("t4_busy", {31'd0, rd_busy_a}, 32'd0);

    // Reset while a commit is pending drops the commit
    step(1'b0, 1'b1, OP_ADD, 3'd1, 32'd77, 4'b1111, 3'd1, 3'd0);
    step(1'b1, 1'b1, OP_ADD, 3'd6, 32'd99, 4'b0110, 3'd1, 3'd6);
    idle(3'd1, 3'd6);
    peek_a(3'd1);
    check("t5_r1", rd_data_a, 32'd0);
    check("t5_flags", {28'd0, flags}, 32'd0);
    check("t5_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Carry export
    step(1'b0, 1'b1, OP_ADC, 3'd0, 32'd5, 4'b0001, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    check("t6_cin_set", {31'd0, cin}, 32'd1);
    step(1'b0, 1'b1, OP_ADD, 3'd7, 32'd6, 4'b0000, 3'd0, 3'd7);
    idle(3'd7, 3'd0);
    check("t6_cin_clr", {31'd0, cin}, 32'd0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      bit         r, en;
      logic [3:0] op;
      logic [2:0] d, ra, rb;
      r  = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 3) == 0) ? OP_CMP : 4'($urandom_range(0, 14));
      d  = 3'($urandom);
      ra = (if_v && $urandom_range(0, 1) == 1) ? if_dest : 3'($urandom);
      rb = (if_v && $urandom_range(0, 2) == 0) ? if_dest : 3'($urandom);
      step(r, en, op, d, 32'($urandom), 4'($urandom), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_writeback
`default_nettype wire
